ccg_sweep_misr: RTL and testbench



---
 rtl/ccg_sweep_misr.sv | 139 +++++++++++++
 tb/tb_ccg_sweep_misr.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccg_sweep_misr.sv
// Exhaustive counting-order sweep of a CUT with MISR compaction of every response; CCG_SWEEP_CMP_EN adds exp_sig/match.
// Latency: done pulses in the cycle 2^N_IN+LAT+1 after start is sampled. Response to vector k is absorbed LAT cycles after it is driven.
// Backpressure: none; resp_in is sampled unconditionally, and start is ignored while busy.
module ccg_sweep_misr #(
    parameter int                N_IN   = 4,
    parameter int                N_OUT  = 19,
    parameter int                MISR_W = 32,
    parameter logic [MISR_W-1:0] POLY   = 32'h0400_0007,
    parameter logic [MISR_W-1:0] SEED   = '0,
    parameter int                LAT    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   vec_out,
    input  logic [N_OUT-1:0]  resp_in,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] sig_out
`ifdef CCG_SWEEP_CMP_EN
    ,
    input  logic [MISR_W-1:0] exp_sig,
    output logic              match
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [N_IN-1:0] VEC_LAST = '1;

    state_t            state;
    logic              upd;
    logic              drain_last;
    logic [MISR_W-1:0] resp_ext;
    logic [MISR_W-1:0] sig_next;

    assign resp_ext = MISR_W'(resp_in);
    assign sig_next = {sig_out[MISR_W-2:0], 1'b0} ^ (sig_out[MISR_W-1] ? POLY : '0) ^ resp_ext;

    // A set bit in the valid pipe marks a response that is due LAT cycles after its vector.
    if (LAT == 0) begin : g_comb
        assign upd        = (state == RUN);
        assign drain_last = 1'b1;
    end else begin : g_pipe
        logic [LAT-1:0] valid_pipe;
        logic [LAT-1:0] pipe_nxt;

        assign pipe_nxt   = (valid_pipe << 1) | LAT'(state == RUN);
        assign upd        = valid_pipe[LAT-1];
        assign drain_last = (pipe_nxt == '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_pipe <= '0;
            end else if (state == IDLE) begin
                valid_pipe <= '0;
            end else begin
                valid_pipe <= pipe_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            vec_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sig_out <= SEED;
`ifdef CCG_SWEEP_CMP_EN
            match   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        vec_out <= '0;
                        sig_out <= SEED;
`ifdef CCG_SWEEP_CMP_EN
                        match   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    // Abort freezes the signature: the response of the abort cycle is not absorbed.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (upd) begin
                            sig_out <= sig_next;
                        end
                        if (vec_out == VEC_LAST) begin
                            if (LAT > 0) begin
                                state <= DRAIN;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            vec_out <= vec_out + N_IN'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (upd) begin
                            sig_out <= sig_next;
                        end
                        if (drain_last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef CCG_SWEEP_CMP_EN
                    match <= (sig_out == exp_sig);
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccg_sweep_misr.sv
// Bench for ccg_sweep_misr: default, LAT=2 and 1-input/4-bit instances, with a signature scoreboard.
`timescale 1ns/1ps
module tb_ccg_sweep_misr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, abort_a, start_b, abort_b, start_c, abort_c;
    logic [3:0]  vec_a, vec_b;
    logic [0:0]  vec_c;
    logic [18:0] resp_a, resp_b, p1, p2;
    logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
    logic [31:0] sig_a, sig_b;
    logic [3:0]  sig_c;
`ifdef CCG_SWEEP_CMP_EN
    logic [31:0] exp_sig_a;
    logic        match_a, match_b, match_c;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int resp_mode = 0;
    int sel = 0;
    logic [31:0] sb_q[$];

    logic        sel_done, sel_busy;
    logic [31:0] sel_sig;
    logic [3:0]  sel_vec;

    function automatic logic [18:0] f_resp(int mode, logic [3:0] v);
        case (mode)
            0:       return '0;
            1:       return {v, ~v, v ^ 4'h5, 3'b101, v + 4'd3};
            default: return {15'd0, v ^ 4'hA};
        endcase
    endfunction

    // Reference signature of the first n responses of a zero-latency sweep.
    function automatic logic [31:0] model_sig(int mode, int n);
        logic [31:0] s;
        s = 32'h0;
        for (int v = 0; v < n; v++) begin
            s = {s[30:0], 1'b0} ^ (s[31] ? 32'h0400_0007 : 32'h0) ^ {13'd0, f_resp(mode, 4'(v))};
        end
        return s;
    endfunction

    assign resp_a = f_resp(resp_mode, vec_a);
    assign resp_b = p2;
    always @(posedge clk) begin
        p1 <= f_resp(2, vec_b);
        p2 <= p1;
    end

    always_comb begin
        sel_done = done_c;
        sel_busy = busy_c;
        sel_sig  = {28'd0, sig_c};
        sel_vec  = {3'd0, vec_c};
        case (sel)
            0: begin sel_done = done_a; sel_busy = busy_a; sel_sig = sig_a; sel_vec = vec_a; end
            1: begin sel_done = done_b; sel_busy = busy_b; sel_sig = sig_b; sel_vec = vec_b; end
            default: ;
        endcase
    end

    ccg_sweep_misr dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .vec_out(vec_a), .resp_in(resp_a), .busy(busy_a), .done(done_a), .sig_out(sig_a)
`ifdef CCG_SWEEP_CMP_EN
        , .exp_sig(exp_sig_a), .match(match_a)
`endif
    );

    ccg_sweep_misr #(.LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .vec_out(vec_b), .resp_in(resp_b), .busy(busy_b), .done(done_b), .sig_out(sig_b)
`ifdef CCG_SWEEP_CMP_EN
        , .exp_sig(32'h0), .match(match_b)
`endif
    );

    ccg_sweep_misr #(.N_IN(1), .N_OUT(1), .MISR_W(4), .POLY(4'h3), .SEED(4'h0), .LAT(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c),
        .vec_out(vec_c), .resp_in(1'b1), .busy(busy_c), .done(done_c), .sig_out(sig_c)
`ifdef CCG_SWEEP_CMP_EN
        , .exp_sig(4'h0), .match(match_c)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input int which, input logic v);
        case (which)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    // Full sweep on one instance; optional extra start pulse at cycle poke_n while busy.
    task automatic run_sweep(input int which, input int exp_n, input logic [31:0] exp_sig,
                             input int poke_n, input string tag);
        int n, bad, nvec;
        logic [31:0] e;
        sel  = which;
        nvec = (which == 2) ? 2 : 16;
        sb_q.push_back(exp_sig);
        @(negedge clk);
        drive_start(which, 1'b1);
        @(posedge clk);
        #1 drive_start(which, 1'b0);
        n   = 0;
        bad = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            drive_start(which, n == poke_n);
            if (n <= nvec && sel_vec != 4'(n - 1)) bad++;
            if (n < exp_n && !sel_busy) bad++;
            if (sel_done) break;
        end
        drive_start(which, 1'b0);
        check({tag, "_done_cycle"}, n, exp_n);
        check({tag, "_vec_busy_seq"}, bad, 0);
        check({tag, "_busy_at_done"}, {31'd0, sel_busy}, 0);
        e = sb_q.pop_front();
        check({tag, "_sig"}, sel_sig, e);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {31'd0, sel_done}, 0);
        check({tag, "_sig_hold"}, sel_sig, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen;
        rst_n = 1'b0;
        start_a = 0; abort_a = 0; start_b = 0; abort_b = 0; start_c = 0; abort_c = 0;
`ifdef CCG_SWEEP_CMP_EN
        exp_sig_a = '0;
`endif
        #12;
        check("rst_vec", {28'd0, vec_a}, 0);
        check("rst_busy", {31'd0, busy_a}, 0);
        check("rst_done", {31'd0, done_a}, 0);
        check("rst_sig", sig_a, 0);
`ifdef CCG_SWEEP_CMP_EN
        check("rst_match", {31'd0, match_a}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        resp_mode = 0;
        run_sweep(0, 17, 32'h0, 0, "a_zero");
        resp_mode = 1;
        run_sweep(0, 17, model_sig(1, 16), 8, "a_mixed");
        run_sweep(2, 3, 32'h3, 0, "c_small");
        run_sweep(1, 19, model_sig(2, 16), 0, "b_lat2");

        // Abort while vector 5 is on vec_out.
        sel = 0;
        @(negedge clk);
        start_a = 1;
        @(posedge clk);
        #1 start_a = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (vec_a != 4'd5 && n < 30);
        check("abort_reach_vec5", n, 6);
        abort_a = 1;
        @(posedge clk);
        #1 abort_a = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_a) seen++;
            if (i == 0) check("abort_busy", {31'd0, busy_a}, 0);
        end
        check("abort_no_done", seen, 0);
        check("abort_sig_frozen", sig_a, model_sig(1, 5));

        // start and abort together in IDLE must not launch a sweep.
        start_a = 1; abort_a = 1;
        @(posedge clk);
        #1 start_a = 0; abort_a = 0;
        @(negedge clk);
        check("start_abort_busy", {31'd0, busy_a}, 0);
        check("start_abort_sig", sig_a, model_sig(1, 5));
        run_sweep(0, 17, model_sig(1, 16), 0, "a_restart");

        // Reset in the middle of DRAIN.
        sel = 1;
        @(negedge clk);
        start_b = 1;
        @(posedge clk);
        #1 start_b = 0;
        for (int i = 0; i < 17; i++) @(negedge clk);
        check("b_drain_busy", {31'd0, busy_b}, 1);
        rst_n = 1'b0;
        #1;
        check("b_rst_busy", {31'd0, busy_b}, 0);
        check("b_rst_vec", {28'd0, vec_b}, 0);
        check("b_rst_sig", sig_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_b) seen++;
        end
        check("b_rst_no_done", seen, 0);
        run_sweep(1, 19, model_sig(2, 16), 10, "b_after_rst");

`ifdef CCG_SWEEP_CMP_EN
        resp_mode = 1;
        exp_sig_a = model_sig(1, 16);
        run_sweep(0, 17, exp_sig_a, 0, "cmp_eq");
        check("cmp_match_eq", {31'd0, match_a}, 1);
        exp_sig_a = exp_sig_a ^ 32'h1;
        run_sweep(0, 17, model_sig(1, 16), 0, "cmp_ne");
        check("cmp_match_ne", {31'd0, match_a}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
